wght_mem_loader: RTL and testbench



---
 rtl/wght_mem_loader.sv | 185 ++++++++++++++++++
 tb/tb_wght_mem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wght_mem_loader.sv
// wght_mem_loader: packs a narrow input beat stream into full-width memory
// lines and writes them to consecutive weight-memory addresses, one line per
// BEATS accepted beats. A load is requested with a single-cycle start pulse.
module wght_mem_loader #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 11,
  parameter int P          = 64,
  parameter int IN_WIDTH   = 32,
  parameter int DEPTH      = 1536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_lines,
  input  logic                  s_valid,
  input  logic [IN_WIDTH-1:0]   s_data,
  output logic                  s_ready,
  output logic                  ena,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [P-1:0]          be,
  output logic [P-1:0]          wea,
  output logic [WIDTH-1:0]      data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BEATS  = WIDTH / IN_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  // One extra bit over num_lines so base + count cannot overflow the check
  localparam int SUM_W  = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH:0]   num_q, num_d;
  logic [ADDR_WIDTH-1:0] line_q, line_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  last_beat;
  logic                  last_line;
  logic [SUM_W-1:0]      end_addr;
  logic                  range_err;

  assign accept    = (state_q == FILL) && s_valid;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_line = (({1'b0, line_q} + {{ADDR_WIDTH{1'b0}}, 1'b1}) == num_q);
  assign end_addr  = SUM_W'(base_addr) + SUM_W'(num_lines);
  assign range_err = (end_addr > SUM_W'(DEPTH));

  // State register plus all datapath flops; reset clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; start is only honoured while idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !range_err) begin
          state_d = (num_lines == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (accept && last_beat) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = last_line ? DONE : FILL;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter, latch and error-pulse updates
  always_comb begin
    base_d = base_q;
    num_d  = num_q;
    line_d = line_q;
    beat_d = beat_q;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (range_err) begin
            err_d = 1'b1;
          end else if (num_lines != '0) begin
            base_d = base_addr;
            num_d  = num_lines;
            line_d = '0;
            beat_d = '0;
          end
        end
      end
      FILL: begin
        if (accept) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
        end
      end
      WRITE: begin
        if (!last_line) begin
          line_d = line_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Each lane of the packing buffer captures s_data when its beat index is accepted
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      assign data_d[gi*IN_WIDTH +: IN_WIDTH] =
        (accept && (beat_q == BEAT_W'(gi))) ? s_data : data_q[gi*IN_WIDTH +: IN_WIDTH];
    end
  endgenerate

  // Outputs decoded purely from the current state
  always_comb begin
    s_ready = 1'b0;
    ena     = 1'b0;
    wren    = 1'b0;
    be      = '0;
    wea     = '0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      FILL: begin
        s_ready = 1'b1;
      end
      WRITE: begin
        ena  = 1'b1;
        wren = 1'b1;
        be   = '1;
        wea  = '1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The start-time range check keeps base + line within the memory
  assign addr = base_q + line_q;
  assign data = data_q;
  assign err  = err_q;

endmodule

// File: tb/tb_wght_mem_loader.sv
// tb_wght_mem_loader: random-stimulus bench with a line-level reference model.
// Loads are modelled as lists of beats; each expected memory line is built by
// shifting beats into place and queued for a negedge monitor to compare.
module tb_wght_mem_loader;

  localparam int W     = 512;
  localparam int AW    = 11;
  localparam int NP    = 64;
  localparam int IW    = 32;
  localparam int DEPTH = 1536;
  localparam int BEATS = W / IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_lines = '0;
  logic          s_valid = 1'b0;
  logic [IW-1:0] s_data = '0;
  logic          s_ready, ena, wren, busy, done, err;
  logic [AW-1:0] addr;
  logic [NP-1:0] be, wea;
  logic [W-1:0]  data;

  wght_mem_loader #(
    .WIDTH(W), .ADDR_WIDTH(AW), .P(NP), .IN_WIDTH(IW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ena(ena), .wren(wren), .addr(addr), .be(be),
    .wea(wea), .data(data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    bit            last;
  } wr_t;

  wr_t           exp_q[$];
  logic [IW-1:0] beat_fifo[$];
  wr_t           mon_e;
  int            chk_cnt = 0;
  int            pass_cnt = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            write_due = -1;
  int            done_due = -1;
  int            err_due = -1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares writes, done and err pulses against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (wren === 1'b1 || cyc == write_due) begin
        chk("write_cycle", W'(wren === 1'b1 ? cyc : -1), W'(write_due));
        write_due = -1;
      end
      if (wren === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", W'(addr), W'(-1));
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_addr", W'(addr), W'(mon_e.waddr));
          chk("write_data", data, mon_e.wdata);
          chk("write_be", W'(be), W'({NP{1'b1}}));
          chk("write_wea", W'(wea), W'({NP{1'b1}}));
          chk("write_ena", W'(ena), W'(1));
          chk("write_s_ready", W'(s_ready), W'(0));
          if (mon_e.last) done_due = cyc + 1;
        end
      end else begin
        chk("idle_strobes", W'({ena, be, wea}), W'(0));
      end
      if (s_valid && s_ready) begin
        acc_cnt++;
        if (acc_cnt % BEATS == 0) write_due = cyc + 1;
      end
      if (done === 1'b1 || cyc == done_due) begin
        chk("done_cycle", W'(done === 1'b1 ? cyc : -1), W'(done_due));
        done_due = -1;
      end
      if (err === 1'b1 || cyc == err_due) begin
        chk("err_cycle", W'(err === 1'b1 ? cyc : -1), W'(err_due));
        chk("err_busy", W'(busy), W'(0));
        err_due = -1;
      end
    end
  end

  // Issue a start pulse; when the DUT is idle, model the load's outcome
  task automatic pulse_start(input int b, input int n, input bit model, input bit seq);
    logic [W-1:0]  line;
    logic [IW-1:0] w;
    start = 1'b1;
    base_addr = AW'(b);
    num_lines = (AW+1)'(n);
    if (model) begin
      if (b + n > DEPTH) err_due = cyc + 1;
      else if (n == 0) done_due = cyc + 1;
      else begin
        for (int l = 0; l < n; l++) begin
          line = '0;
          for (int k = 0; k < BEATS; k++) begin
            w = seq ? IW'(k) : IW'($urandom);
            beat_fifo.push_back(w);
            line = line | (W'(w) << (IW * k));
          end
          exp_q.push_back('{waddr: AW'(b + l), wdata: line, last: (l == n - 1)});
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom);
    num_lines = (AW+1)'($urandom);
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input int gmax);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      chk("beat_accept_timeout", W'(s_ready), W'(1));
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_data = IW'($urandom);
    repeat ($urandom_range(0, gmax)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_n(input int cnt, input int gmax);
    for (int i = 0; i < cnt && beat_fifo.size() > 0; i++) send_beat(beat_fifo.pop_front(), gmax);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || done_due >= 0 || err_due >= 0 || busy === 1'b1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("quiet_timeout", W'(n < 500), W'(1));
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, W'({s_ready, ena, wren, busy, done, err}), W'(0));
    chk({nm, "_be_wea"}, W'({be, wea}), W'(0));
    chk({nm, "_addr"}, W'(addr), W'(0));
    chk({nm, "_data"}, data, W'(0));
  endtask

  task automatic load(input int b, input int n, input int gmax, input bit seq);
    pulse_start(b, n, 1'b1, seq);
    send_n(beat_fifo.size(), gmax);
    wait_quiet();
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One line, sequential beats, back-to-back
    load(0, 1, 0, 1'b1);
    // Three lines with random gaps
    load(100, 3, 3, 1'b0);
    // Range error, then the largest legal load ending at the last line
    pulse_start(1530, 7, 1'b1, 1'b0);
    repeat (3) begin
      chk("err_case_busy", W'(busy), W'(0));
      @(posedge clk); #1;
    end
    wait_quiet();
    load(1530, 6, 1, 1'b0);
    // Zero-line load
    load(50, 0, 0, 1'b0);

    // Reset after 9 beats of line 0 discards the load
    pulse_start(200, 2, 1'b1, 1'b0);
    send_n(9, 0);
    rst_n = 1'b0;
    exp_q.delete();
    beat_fifo.delete();
    acc_cnt = 0;
    write_due = -1;
    done_due = -1;
    err_due = -1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    load(300, 1, 2, 1'b0);

    // A start during FILL must be ignored
    pulse_start(400, 2, 1'b1, 1'b0);
    send_n(5, 1);
    pulse_start(800, 5, 1'b0, 1'b0);
    send_n(beat_fifo.size(), 1);
    wait_quiet();

    // Random loads, including occasional range errors
    for (int t = 0; t < 8; t++) begin
      load($urandom_range(1520, 1535) - (t % 2) * $urandom_range(0, 1500),
           $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
